// File: rtl/rgb888_word_packer.sv
// Write-side packer for the MIPI TX line buffer: packs RGB888 pixels into
// little-endian 32-bit FIFO words, enforces line length and flushes short lines.
module rgb888_word_packer #(
    parameter int PIX_PER_LINE = 1080
) (
    input  logic        wclk,
    input  logic        wrst_n,
    input  logic        pix_valid,
    input  logic [23:0] pix_data,
    input  logic        line_start,
    output logic        pix_ready,
    input  logic        fifo_wfull,
    output logic [31:0] fifo_wdata,
    output logic        fifo_wen,
    output logic        line_done,
    output logic        err_short,
    output logic        err_long,
    input  logic        err_clr
);

    localparam int WORDS_PER_LINE = PIX_PER_LINE * 3 / 4;
    localparam int WCNT_W         = $clog2(WORDS_PER_LINE + 1);

    localparam logic [10:0]       PIX_FULL  = 11'(PIX_PER_LINE);
    localparam logic [10:0]       PIX_LAST  = 11'(PIX_PER_LINE - 1);
    localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE
    } state_t;

    // Word written when the pixel at phase ph is combined with the residue.
    function automatic logic [31:0] pack_word(input logic [1:0] ph, input logic [23:0] px,
                                              input logic [23:0] r);
        case (ph)
            2'd1:    pack_word = {px[7:0], r[23:0]};
            2'd2:    pack_word = {px[15:0], r[15:0]};
            2'd3:    pack_word = {px[23:0], r[7:0]};
            default: pack_word = 32'h0;
        endcase
    endfunction

    function automatic logic [23:0] next_res(input logic [1:0] ph, input logic [23:0] px,
                                             input logic [23:0] r);
        case (ph)
            2'd0:    next_res = px;
            2'd1:    next_res = {r[23:16], px[23:8]};
            2'd2:    next_res = {r[23:8], px[23:16]};
            default: next_res = r;
        endcase
    endfunction

    // Residue left over at phase ph, zero-padded in the upper bytes.
    function automatic logic [31:0] flush_word(input logic [1:0] ph, input logic [23:0] r);
        case (ph)
            2'd1:    flush_word = {8'h0, r[23:0]};
            2'd2:    flush_word = {16'h0, r[15:0]};
            2'd3:    flush_word = {24'h0, r[7:0]};
            default: flush_word = 32'h0;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [23:0]       res_q, res_d;
    logic [10:0]       pix_cnt_q, pix_cnt_d;
    logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              wen_q, wen_d;
    logic              line_done_q, line_done_d;
    logic              err_short_q, err_short_d;
    logic              err_long_q, err_long_d;
    logic              acc;
    logic              set_short;
    logic              set_long;

    assign pix_ready = ~fifo_wfull;
    assign acc       = pix_valid & pix_ready;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        res_d       = res_q;
        pix_cnt_d   = pix_cnt_q;
        word_cnt_d  = word_cnt_q;
        wdata_d     = wdata_q;
        wen_d       = 1'b0;
        line_done_d = 1'b0;
        set_short   = 1'b0;
        set_long    = 1'b0;

        if (acc) begin
            if (line_start) begin
                if (state_q == S_ACTIVE && pix_cnt_q != 11'd0 && pix_cnt_q != PIX_FULL) begin
                    set_short = 1'b1;
                    if (phase_q != 2'd0) begin
                        wen_d   = 1'b1;
                        wdata_d = flush_word(phase_q, res_q);
                    end
                end
                // The line_start pixel itself is pixel 0 of the new line.
                state_d    = S_ACTIVE;
                res_d      = pix_data;
                phase_d    = 2'd1;
                pix_cnt_d  = 11'd1;
                word_cnt_d = '0;
            end else if (state_q == S_ACTIVE) begin
                res_d     = next_res(phase_q, pix_data, res_q);
                phase_d   = phase_q + 2'd1;
                pix_cnt_d = pix_cnt_q + 11'd1;
                if (phase_q != 2'd0) begin
                    wen_d       = 1'b1;
                    wdata_d     = pack_word(phase_q, pix_data, res_q);
                    word_cnt_d  = word_cnt_q + 1'b1;
                    line_done_d = (word_cnt_q == WORD_LAST);
                end
                if (pix_cnt_q == PIX_LAST) begin
                    state_d = S_DONE;
                end
            end else if (state_q == S_DONE) begin
                set_long = 1'b1;
            end
        end

        err_short_d = err_clr ? 1'b0 : (err_short_q | set_short);
        err_long_d  = err_clr ? 1'b0 : (err_long_q | set_long);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q     <= S_IDLE;
            phase_q     <= 2'd0;
            res_q       <= 24'h0;
            pix_cnt_q   <= 11'd0;
            word_cnt_q  <= '0;
            wdata_q     <= 32'h0;
            wen_q       <= 1'b0;
            line_done_q <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            res_q       <= res_d;
            pix_cnt_q   <= pix_cnt_d;
            word_cnt_q  <= word_cnt_d;
            wdata_q     <= wdata_d;
            wen_q       <= wen_d;
            line_done_q <= line_done_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

    assign fifo_wdata = wdata_q;
    assign fifo_wen   = wen_q;
    assign line_done  = line_done_q;
    assign err_short  = err_short_q;
    assign err_long   = err_long_q;

endmodule

// File: tb/tb_rgb888_word_packer.sv
// Randomized scoreboard bench for rgb888_word_packer; the reference model
// treats each line as a little-endian byte stream cut into 32-bit words.
module tb_rgb888_word_packer;

    localparam int PPL = 1080;
    localparam int WPL = PPL * 3 / 4;

    logic        wclk = 1'b0;
    logic        wrst_n;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        line_start;
    logic        pix_ready;
    logic        fifo_wfull;
    logic [31:0] fifo_wdata;
    logic        fifo_wen;
    logic        line_done;
    logic        err_short;
    logic        err_long;
    logic        err_clr;

    rgb888_word_packer #(.PIX_PER_LINE(PPL)) dut (
        .wclk       (wclk),
        .wrst_n     (wrst_n),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .line_start (line_start),
        .pix_ready  (pix_ready),
        .fifo_wfull (fifo_wfull),
        .fifo_wdata (fifo_wdata),
        .fifo_wen   (fifo_wen),
        .line_done  (line_done),
        .err_short  (err_short),
        .err_long   (err_long),
        .err_clr    (err_clr)
    );

    always #5 wclk = ~wclk;

    int checks = 0;
    int passes = 0;
    int wr_seen = 0;
    int ld_seen = 0;
    int exp_wr = 0;
    int exp_ld = 0;
    logic [31:0] first_words [3];

    logic [32:0] exp_q [$];
    logic [7:0]  bq [$];
    int          m_state = 0;  // 0 idle, 1 in line, 2 line complete
    int          m_pix = 0;
    int          m_words = 0;
    logic        m_es = 1'b0;
    logic        m_el = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model for one accepted pixel; returns whether a word is written.
    function automatic bit model_beat(input logic [23:0] d, input logic ls);
        bit          wrote = 1'b0;
        logic [31:0] w;
        if (ls) begin
            if (m_state == 1 && m_pix != 0 && m_pix != PPL) begin
                m_es = 1'b1;
                if (bq.size() > 0) begin
                    w = '0;
                    for (int i = 0; i < bq.size(); i++) w[8*i +: 8] = bq[i];
                    exp_q.push_back({1'b0, w});
                    exp_wr++;
                    wrote = 1'b1;
                end
            end
            bq.delete();
            m_pix   = 0;
            m_words = 0;
            m_state = 1;
        end else if (m_state != 1) begin
            if (m_state == 2) m_el = 1'b1;
            return 1'b0;
        end
        bq.push_back(d[7:0]);
        bq.push_back(d[15:8]);
        bq.push_back(d[23:16]);
        m_pix++;
        if (bq.size() >= 4) begin
            w = {bq[3], bq[2], bq[1], bq[0]};
            repeat (4) void'(bq.pop_front());
            m_words++;
            exp_q.push_back({(m_words == WPL), w});
            exp_wr++;
            if (m_words == WPL) exp_ld++;
            wrote = 1'b1;
        end
        if (m_pix == PPL) m_state = 2;
        return wrote;
    endfunction

    // Called at posedge+1; drives one cycle of inputs and checks after the next edge.
    task automatic beat(input logic v, input logic [23:0] d, input logic ls,
                        input logic full, input logic clr);
        bit exp_wen = 1'b0;
        pix_valid  = v;
        pix_data   = d;
        line_start = ls;
        fifo_wfull = full;
        err_clr    = clr;
        #1;
        chk("pix_ready", 64'(pix_ready), 64'(!full));
        if (v && !full) exp_wen = model_beat(d, ls);
        if (clr) begin
            m_es = 1'b0;
            m_el = 1'b0;
        end
        @(posedge wclk);
        #1;
        chk("wen_latency", 64'(fifo_wen), 64'(exp_wen));
        chk("err_short", 64'(err_short), 64'(m_es));
        chk("err_long", 64'(err_long), 64'(m_el));
    endtask

    always @(negedge wclk) begin
        logic [32:0] e;
        if (wrst_n && fifo_wen) begin
            if (wr_seen < 3) first_words[wr_seen] = fifo_wdata;
            wr_seen++;
            if (line_done) ld_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got wdata %08h, required no write (t=%0t)",
                         fifo_wdata, $time);
            end else begin
                e = exp_q.pop_front();
                chk("wdata", 64'(fifo_wdata), 64'(e[31:0]));
                chk("line_done", 64'(line_done), 64'(e[32]));
            end
        end else if (wrst_n && line_done) begin
            chk("line_done_without_wen", 64'(line_done), 64'(0));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        wrst_n     = 1'b0;
        pix_valid  = 1'b0;
        pix_data   = 24'h0;
        line_start = 1'b0;
        fifo_wfull = 1'b0;
        err_clr    = 1'b0;
        #2;
        chk("rst_wen", 64'(fifo_wen), 64'(0));
        chk("rst_wdata", 64'(fifo_wdata), 64'(0));
        chk("rst_line_done", 64'(line_done), 64'(0));
        chk("rst_err_short", 64'(err_short), 64'(0));
        chk("rst_err_long", 64'(err_long), 64'(0));
        fifo_wfull = 1'b1;
        #1 chk("rst_ready_full", 64'(pix_ready), 64'(0));
        fifo_wfull = 1'b0;
        #1 chk("rst_ready", 64'(pix_ready), 64'(1));
        repeat (2) @(posedge wclk);
        #1 wrst_n = 1'b1;

        // Line 1: incrementing data, back-to-back, 10-cycle full stall mid-line.
        for (int i = 0; i < PPL; i++) begin
            if (i == 500) repeat (10) beat(1'b1, 24'(i + 1), 1'b0, 1'b1, 1'b0);
            if (i > 600 && $urandom_range(3) == 0) beat(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
            beat(1'b1, 24'(i + 1), (i == 0), 1'b0, 1'b0);
        end
        beat(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        chk("first_word0", 64'(first_words[0]), 64'(32'h02000001));
        chk("first_word1", 64'(first_words[1]), 64'(32'h00030000));
        chk("first_word2", 64'(first_words[2]), 64'(32'h00000400));
        chk("line1_writes", 64'(wr_seen), 64'(WPL));
        chk("line1_done_pulses", 64'(ld_seen), 64'(1));

        // Overlong line, clear, and clear priority over a same-cycle set.
        beat(1'b1, 24'hABCDEF, 1'b0, 1'b0, 1'b0);
        beat(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
        beat(1'b1, 24'h123456, 1'b0, 1'b0, 1'b1);
        beat(1'b1, 24'h654321, 1'b0, 1'b0, 1'b0);
        beat(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);

        // Short line of 5 pixels, then a new line that must pack from phase 0.
        for (int i = 0; i < 5; i++) beat(1'b1, 24'($urandom), (i == 0), 1'b0, 1'b0);
        beat(1'b1, 24'($urandom), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) beat(1'b1, 24'($urandom), 1'b0, 1'b0, 1'b0);

        // Random short lines with random gaps and backpressure.
        for (int l = 0; l < 8; l++) begin
            int len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                while ($urandom_range(4) == 0)
                    beat(1'b1, 24'($urandom), 1'b0, 1'b1, 1'b0);
                beat(1'b1, 24'($urandom), (i == 0), 1'b0, 1'b0);
            end
        end
        beat(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);

        // Full random line under random valid and full.
        for (int i = 0; i < PPL; i++) begin
            while ($urandom_range(5) == 0)
                beat($urandom_range(1) == 1, 24'($urandom), 1'b0, $urandom_range(1) == 1, 1'b0);
            beat(1'b1, 24'($urandom), (i == 0), 1'b0, 1'b0);
        end
        beat(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        chk("line2_done_pulses", 64'(ld_seen), 64'(2));

        // Reset asserted mid-line with a phase-2 write on the port.
        beat(1'b1, 24'h111111, 1'b1, 1'b0, 1'b0);
        beat(1'b1, 24'h222222, 1'b0, 1'b0, 1'b0);
        pix_valid  = 1'b1;
        pix_data   = 24'h333333;
        line_start = 1'b0;
        void'(model_beat(24'h333333, 1'b0));
        @(posedge wclk);
        #1;
        chk("pre_reset_wen", 64'(fifo_wen), 64'(1));
        wrst_n    = 1'b0;
        pix_valid = 1'b0;
        #1;
        chk("reset_wen_drop", 64'(fifo_wen), 64'(0));
        chk("reset_wdata", 64'(fifo_wdata), 64'(0));
        exp_wr  -= exp_q.size();
        exp_q.delete();
        bq.delete();
        m_state = 0;
        m_pix   = 0;
        m_words = 0;
        m_es    = 1'b0;
        m_el    = 1'b0;
        repeat (2) @(posedge wclk);
        #1 wrst_n = 1'b1;
        for (int i = 0; i < 8; i++) beat(1'b1, 24'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) beat(1'b1, 24'($urandom), (i == 0), 1'b0, 1'b0);
        beat(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        beat(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        chk("total_writes", 64'(wr_seen), 64'(exp_wr));
        chk("total_line_done", 64'(ld_seen), 64'(exp_ld));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rgb888_word_packer.md
# rgb888_word_packer

Write-side packer for the MIPI TX line buffer. It accepts one 24-bit RGB888 pixel per cycle from the scaler, packs every 4 pixels into 3 little-endian 32-bit words, and drives the write port of the 32-bit × 1k line FIFO in the `wclk` domain. It also enforces the line length, flushes partial words on short lines, and pulses `line_done` when a complete line is in the FIFO. That pulse is used for the read-side start threshold of 810 words.

## Interface
Parameters:
- `PIX_PER_LINE`, default 1080: pixels per line. Must be a multiple of 4 and ≤ 2044. Words per line = `PIX_PER_LINE*3/4` (default 810).

Ports:
- `wclk`  in  1  write-domain clock; all logic is on its rising edge
- `wrst_n`  in  1  asynchronous, active-low reset; one clock, no other reset
- `pix_valid`  in  1  pixel qualifier
- `pix_data`  in  24  pixel, {R[23:16], G[15:8], B[7:0]}
- `line_start`  in  1  marks the first pixel of a line; sampled only on an accepted beat
- `pix_ready`  out  1  packer can accept a pixel this cycle
- `fifo_wfull`  in  1  FIFO full flag
- `fifo_wdata`  out  32  packed word
- `fifo_wen`  out  1  write strobe, registered
- `line_done`  out  1  one-cycle pulse with the last word of a complete line
- `err_short`  out  1  sticky: `line_start` arrived before `PIX_PER_LINE` pixels
- `err_long`  out  1  sticky: pixels were received beyond `PIX_PER_LINE`
- `err_clr`  in  1  synchronous clear of both sticky flags

## Operation
- Accept condition: `acc = pix_valid & pix_ready`, with `pix_ready = ~fifo_wfull`, combinational.
- State machine with three states:
  - IDLE (the reset state): accepted pixels without `line_start` are dropped, with no error.
  - ACTIVE: packing a line.
  - DONE: the line is complete.
- State transitions:
  - An accepted beat with `line_start` goes to ACTIVE from any state. It clears `pix_cnt` and sets `phase=0` before this pixel is processed.
  - ACTIVE goes to DONE on the accept that makes `pix_cnt == PIX_PER_LINE`.
  - In DONE, an accepted pixel without `line_start` is dropped and sets `err_long`.
- Packing uses a 2-bit phase and a 24-bit residue register `res`. Pn denotes the pixel accepted at phase n.
  - phase 0: `res <= p0`; no write.
  - phase 1: write {p1[7:0], res[23:0]}; `res[15:0] <= p1[23:8]`.
  - phase 2: write {p2[15:0], res[15:0]}; `res[7:0] <= p2[23:16]`.
  - phase 3: write {p3[23:0], res[7:0]}.
  - Phase increments modulo 4 on each accepted pixel in ACTIVE.
- Short line: `line_start` is accepted in ACTIVE with `pix_cnt` neither 0 nor `PIX_PER_LINE`.
  - `err_short` is set.
  - If phase ≠ 0, the residue is flushed zero-padded in the upper bytes, e.g. phase 1 gives {8'h0, res[23:0]}. This is a single write issued for that cycle. The new pixel is at phase 0, so no second write is needed.
  - `line_done` is not pulsed for a short line.
- `line_start` in DONE or IDLE is normal and sets no error.
- `line_done` asserts together with the `fifo_wen` carrying word number `PIX_PER_LINE*3/4` of the line.
- `err_clr` has priority over a same-cycle set. Both flags read 0 on the next cycle.

## Timing
- Outputs under reset (async assert):
  - `fifo_wen=0`, `fifo_wdata=0`, `line_done=0`, `err_short=0`, `err_long=0`.
  - State IDLE, `phase=0`, `res=0`, counters 0.
  - `pix_ready` then follows `~fifo_wfull`.
- Latency: the pixel accepted in cycle N produces its write (`fifo_wen`=1 and data) in cycle N+1.
- Throughput: 1 pixel/cycle sustained, i.e. 3 writes per 4 cycles.
- Backpressure: `fifo_wen` is registered one cycle behind `fifo_wfull`. The FIFO must therefore accept one write after asserting full. The 1024-entry buffer holding 810-word lines meets this with margin.
- Reset mid-line discards any partial word; no flush is issued. The FIFO shares `wrst_n`.
- Counter widths: `pix_cnt` 11 bits, `word_cnt` 10 bits. Neither wraps within a legal line.

## Test plan
- Reset, then `line_start` and pixels 0x000001..0x000004 back-to-back:
  - writes in cycles 2, 3 and 4 after the first pixel;
  - data 32'h02000001, 32'h00030000, 32'h00000400.
- Full 1080-pixel line of incrementing data:
  - exactly 810 writes;
  - `line_done` coincident with the 810th write;
  - no errors.
- Pixel 1081 without `line_start`: no write, `err_long`=1. Then assert `err_clr`: flag 0 next cycle.
- Short line of 5 pixels, then `line_start`:
  - one flush write {8'h0, p4} is issued;
  - `err_short`=1;
  - no `line_done`;
  - the new line packs from phase 0.
- Hold `fifo_wfull`=1 for 10 cycles mid-line:
  - `pix_ready`=0;
  - no pixels lost or duplicated;
  - resumed data continues the correct sequence.
- Assert `wrst_n` low mid-line at phase 2:
  - `fifo_wen` drops immediately;
  - no flush is issued;
  - pixels without `line_start` after release are dropped.
